// File: rtl/ped_pkg.sv
// ped_pkg -- shared types and constants for the pedestrian request unit.
//   ped_state_e         : request FSM state encoding (2 bits, code 2'b11 unused)
//   WALK_CODE_DEF       : default lightseq value that marks the walk phase
//   DEBOUNCE_CYCLES_DEF : default debounce length in synchronised samples
//   cnt_width()         : debounce counter width for a given debounce length
//   CNT_W_DEF           : counter width at the default debounce length
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    WALK  = 2'b10
  } ped_state_e;

  localparam logic [4:0] WALK_CODE_DEF       = 5'b10100;
  localparam int         DEBOUNCE_CYCLES_DEF = 4;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/ped_debounce.sv
// ped_debounce -- button synchroniser, debouncer and press-pulse generator.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   button : raw bouncing push-button, 1 = pressed
//   press  : registered one-cycle pulse on each accepted 0->1 of the button
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count-th differing sample is the one that flips the level, so the
  // compare is against DEBOUNCE_CYCLES-1 held in the counter.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) level_d = ~level_q;
      else               cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/ped_request.sv
// ped_request -- pedestrian request unit driving the crossing controller.
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   button    : raw push-button, 1 = pressed
//   lightseq  : controller light sequence (walk when equal to WALK_CODE)
//   start     : registered request level to the controller
//   wait_lamp : registered WAIT indicator
//   req_count : saturating count of request entries (only with PED_REQ_COUNT_EN)
// Build option: define PED_REQ_COUNT_EN to add the req_count output.
module ped_request
  import ped_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [4:0] WALK_CODE       = WALK_CODE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic [4:0] lightseq,
  output logic       start,
`ifdef PED_REQ_COUNT_EN
  output logic [7:0] req_count,
`endif
  output logic       wait_lamp
);

  ped_state_e state_q, state_d;
  logic       pending_q, pending_d;
  logic       start_q, wait_q;
  logic       press;
  logic       walk;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clock (clock),
    .reset (reset),
    .button(button),
    .press (press)
  );

  assign walk = (lightseq == WALK_CODE);

  // Walk transitions win over a press arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE:  if (press) state_d = ARMED;
      ARMED: if (walk)  state_d = WALK;
      WALK: begin
        if (!walk) begin
          state_d   = pending_q ? ARMED : IDLE;
          pending_d = 1'b0;
        end else if (press) begin
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

`ifdef PED_REQ_COUNT_EN
  logic [7:0] count_q;
  logic       enter_armed;
  assign enter_armed = (state_d == ARMED) && (state_q != ARMED);
  assign req_count   = count_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      wait_q    <= 1'b0;
`ifdef PED_REQ_COUNT_EN
      count_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      start_q   <= (state_d == ARMED);
      wait_q    <= (state_d == ARMED);
`ifdef PED_REQ_COUNT_EN
      if (enter_armed && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
`endif
    end
  end

  assign start     = start_q;
  assign wait_lamp = wait_q;

endmodule

// File: tb/tb_ped_request.sv
module tb_ped_request;

  localparam int         D     = 4;
  localparam logic [4:0] WALKV = 5'b10100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic [4:0] lightseq = 5'd0;
  logic       start, wait_lamp;
`ifdef PED_REQ_COUNT_EN
  logic [7:0] req_count;
`endif

  ped_request u_dut (
    .clock    (clock),
    .reset    (reset),
    .button   (button),
    .lightseq (lightseq),
    .start    (start),
`ifdef PED_REQ_COUNT_EN
    .req_count(req_count),
`endif
    .wait_lamp(wait_lamp)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  int press_cnt = 0;
  always @(posedge clock) if (u_dut.press === 1'b1) press_cnt <= press_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 30) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    button   = 1'b0;
    lightseq = 5'd0;
    #1;
    check("reset_start", start, 0);
    check("reset_wait", wait_lamp, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // Hold the button long enough for one accepted press, then release and let it settle.
  task automatic press_button();
    button = 1'b1;
    repeat (D + 3) tick();
    button = 1'b0;
    repeat (D + 3) tick();
  endtask

  // ---------------- behavioural reference model ----------------
  // Request lifecycle: idle -> outstanding request -> walk phase (with optional
  // queued follow-up). The button is accepted after D consecutive synchronised
  // samples that disagree with the current accepted level.
  bit m_btn[$];
  bit m_win[$];
  bit m_level, m_press, m_req, m_walk, m_pend;

  task automatic model_reset();
    m_btn.delete();
    m_win.delete();
    m_btn.push_back(1'b0);
    m_btn.push_back(1'b0);
    for (int i = 0; i < D; i++) m_win.push_back(1'b0);
    m_level = 0; m_press = 0; m_req = 0; m_walk = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit b, input logic [4:0] ls);
    bit w, s, all_diff;
    w = (ls == WALKV);
    if (m_walk) begin
      if (!w) begin
        m_walk = 0;
        m_req  = m_pend;
        m_pend = 0;
      end else if (m_press) begin
        m_pend = 1;
      end
    end else if (m_req) begin
      if (w) begin
        m_req  = 0;
        m_walk = 1;
      end
    end else if (m_press) begin
      m_req = 1;
    end
    m_btn.push_back(b);
    s = m_btn.pop_front();
    m_win.push_back(s);
    void'(m_win.pop_front());
    all_diff = 1;
    foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 0;
    m_press = 0;
    if (all_diff) begin
      m_level = !m_level;
      m_press = m_level;
    end
  endtask

  typedef struct {
    logic       btn;
    logic [4:0] ls;
    logic       exp_start;
  } vec_t;

  vec_t vecs[0:12];

  initial begin
    int base, bad;
    bit rb;
    logic [4:0] rls;
    int bhold, lhold;

    // press latency, handshake, walk ignored while idle
    for (int i = 0; i < 6; i++) vecs[i] = '{1'b1, 5'd0, 1'b0};
    vecs[6]  = '{1'b1, 5'd0,     1'b1};
    vecs[7]  = '{1'b0, 5'd0,     1'b1};
    vecs[8]  = '{1'b0, 5'b10100, 1'b0};
    vecs[9]  = '{1'b0, 5'b01001, 1'b0};
    vecs[10] = '{1'b0, 5'd0,     1'b0};
    vecs[11] = '{1'b0, 5'b10100, 1'b0};
    vecs[12] = '{1'b0, 5'd0,     1'b0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      button   = vecs[i].btn;
      lightseq = vecs[i].ls;
      tick();
      check($sformatf("vec%0d_start", i), start, vecs[i].exp_start);
      check($sformatf("vec%0d_wait", i), wait_lamp, vecs[i].exp_start);
    end
    repeat (4) tick();

    // async reset mid-clock while armed
    button = 1'b1;
    repeat (D + 3) tick();
    check("armed_before_reset", start, 1);
    @(negedge clock);
    reset  = 1'b0;
    button = 1'b0;
    #1;
    check("async_reset_start", start, 0);
    check("async_reset_wait", wait_lamp, 0);
    tick();
    reset = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (start !== 1'b0 || wait_lamp !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    // bounce then stable high
    base = press_cnt;
    button = 1'b1; tick();
    button = 1'b0; tick();
    button = 1'b1; tick();
    button = 1'b0; tick();
    button = 1'b1;
    for (int k = 1; k <= D + 3; k++) begin
      tick();
      check($sformatf("bounce_start_k%0d", k), start, (k == D + 3) ? 1 : 0);
    end
    check("bounce_wait", wait_lamp, 1);
    repeat (5) tick();
    check("bounce_one_press", press_cnt - base, 1);
    button = 1'b0;
    repeat (D + 4) tick();

    // press during walk is queued
    lightseq = WALKV;
    tick();
    check("walk_start_low", start, 0);
    button = 1'b1;
    repeat (D + 3) tick();
    button = 1'b0;
    repeat (D + 3) tick();
    check("walk_hold_low", start, 0);
    lightseq = 5'b01110;
    tick();
    check("pending_rearm_start", start, 1);
    check("pending_rearm_wait", wait_lamp, 1);
    lightseq = WALKV; tick();
    lightseq = 5'd0;  tick();
    check("pending_cleared", start, 0);
    tick();
    check("idle_stays", start, 0);

    // long hold gives one request
    base = press_cnt;
    button = 1'b1;
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == D + 2) check("hold_before_start", start, 0);
      if (k >= D + 3 && start !== 1'b1) bad++;
    end
    check("hold_start_steady", bad, 0);
    check("hold_one_press", press_cnt - base, 1);
    button = 1'b0;
    repeat (D + 4) tick();
    check("hold_release_armed", start, 1);
    lightseq = WALKV; tick();
    lightseq = 5'd0;  tick();
    check("hold_back_idle", start, 0);

`ifdef PED_REQ_COUNT_EN
    do_reset();
    check("count_reset", req_count, 0);
    for (int n = 0; n < 260; n++) begin
      press_button();
      lightseq = WALKV; tick();
      lightseq = 5'd0;  tick();
      if (n == 0)   check("count_first", req_count, 1);
      if (n == 253) check("count_254", req_count, 254);
    end
    check("count_saturated", req_count, 255);
`endif

    // randomized run against the reference model
    do_reset();
    model_reset();
    button = 1'b0; lightseq = 5'd0;
    bhold = 0; lhold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bhold == 0) begin
        button = ~button;
        bhold  = $urandom_range(1, 10);
      end
      bhold--;
      if (lhold == 0) begin
        if ($urandom_range(0, 2) == 0) rls = WALKV;
        else begin
          rls = 5'($urandom);
          if (rls == WALKV) rls[0] = ~rls[0];
        end
        lightseq = rls;
        lhold    = $urandom_range(1, 15);
      end
      lhold--;
      rb = button;
      @(posedge clock);
      model_step(rb, lightseq);
      #1;
      check("rand_start", start, m_req);
      check("rand_wait", wait_lamp, m_req);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
